// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter: parity modes, FSM states, data-width bounds.
// ST_BREAK exists only when UART_TRANSMITTER_EX_BREAK_EN is defined.
package uart_pkg;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_EVEN  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
`ifdef UART_TRANSMITTER_EX_BREAK_EN
    , ST_BREAK = 3'd5
`endif
  } state_e;

  // Parity bit over the low nbits of data for the given mode.
  function automatic logic parity_bit(input parity_e mode,
                                      input logic [DATA_BITS_MAX-1:0] data,
                                      input logic [3:0] nbits);
    logic x;
    logic r;
    x = 1'b0;
    for (int i = 0; i < DATA_BITS_MAX; i++) begin
      if (4'(i) < nbits) x = x ^ data[i];
      else x = x;
    end
    case (mode)
      PAR_EVEN:  r = x;
      PAR_ODD:   r = ~x;
      PAR_MARK:  r = 1'b1;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..divisor-1 (divisor 0 behaves as 1) and flags the final clock.
// clr restarts the period so a new bit begins on the following clock.
module uart_baud_tick #(
  parameter int BDWIDTH = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic [BDWIDTH-1:0] divisor,
  output logic               tick
);

  localparam logic [BDWIDTH-1:0] ONE  = BDWIDTH'(1);
  localparam logic [BDWIDTH-1:0] ZERO = {BDWIDTH{1'b0}};

  logic [BDWIDTH-1:0] cnt_q, cnt_d, last_s;

  always_comb begin
    if (divisor == ZERO) last_s = ZERO;
    else last_s = divisor - ONE;
    tick = (cnt_q == last_s);
    if (clr) cnt_d = ZERO;
    else if (tick) cnt_d = ZERO;
    else cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= ZERO;
    else cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_transmitter_ex.sv
// Streaming UART transmitter with configurable framing; break generation is compiled in
// only when UART_TRANSMITTER_EX_BREAK_EN is defined.
module uart_transmitter_ex
  import uart_pkg::*;
#(
  parameter int BDWIDTH = 16,
  parameter int DWIDTH  = 9
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ctrl_init,
  input  logic [BDWIDTH-1:0] ctrl_baud_divisor,
  input  logic [3:0]         ctrl_data_bits,
  input  logic [2:0]         ctrl_parity_mode,
  input  logic               ctrl_stop_bits,
  input  logic               ctrl_break,
  input  logic [DWIDTH-1:0]  tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic               uart_txd,
  output logic               tx_busy
);

  state_e                   state_q, state_d;
  parity_e                  pmode_q, pmode_d, pmode_s;
  logic                     txd_q, txd_d;
  logic [3:0]               bit_cnt_q, bit_cnt_d;
  logic [DWIDTH-1:0]        sh_q, sh_d;
  logic [BDWIDTH-1:0]       div_q, div_d;
  logic [3:0]               nbits_q, nbits_d, nbits_s;
  logic                     par_bit_q, par_bit_d, stop2_q, stop2_d;
  logic                     tick_s, clr_s, last_stop_s, xfer_s, brk_enter_s, load_s;
  logic [DATA_BITS_MAX-1:0] data_ext_s;

  uart_baud_tick #(.BDWIDTH(BDWIDTH)) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr_s),
    .divisor (div_q),
    .tick    (tick_s)
  );

  always_comb begin
    if ((ctrl_data_bits < 4'(DATA_BITS_MIN)) || (ctrl_data_bits > 4'(DWIDTH))) nbits_s = 4'(DWIDTH);
    else nbits_s = ctrl_data_bits;
    if (ctrl_parity_mode > 3'd4) pmode_s = PAR_NONE;
    else pmode_s = parity_e'(ctrl_parity_mode);
    data_ext_s = {DATA_BITS_MAX{1'b0}};
    data_ext_s[DWIDTH-1:0] = tx_data;
  end

  assign last_stop_s = (state_q == ST_STOP) && tick_s && (!stop2_q || (bit_cnt_q == 4'd1));
  assign tx_ready    = (state_q == ST_IDLE) || last_stop_s;
  assign xfer_s      = tx_valid && tx_ready;
  assign load_s      = (xfer_s || brk_enter_s) && !ctrl_init;
  assign tx_busy     = (state_q != ST_IDLE);
  assign uart_txd    = txd_q;

`ifdef UART_TRANSMITTER_EX_BREAK_EN
  logic       brk_hi_q, brk_hi_d, brk_done_s;
  logic [3:0] fb_s;
  // Break is measured against start + data + parity + stop bits of the settings latched on entry.
  assign fb_s        = 4'd2 + nbits_q + {3'b000, (pmode_q != PAR_NONE)} + {3'b000, stop2_q};
  assign brk_done_s  = (bit_cnt_q == fb_s) || (tick_s && (bit_cnt_q == (fb_s - 4'd1)));
  assign brk_enter_s = ctrl_break && !xfer_s && ((state_q == ST_IDLE) || last_stop_s);
`else
  logic unused_brk_s;
  assign unused_brk_s = ctrl_break;
  assign brk_enter_s  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    txd_d     = txd_q;
    sh_d      = load_s ? tx_data : sh_q;
    div_d     = load_s ? ctrl_baud_divisor : div_q;
    nbits_d   = load_s ? nbits_s : nbits_q;
    pmode_d   = load_s ? pmode_s : pmode_q;
    stop2_d   = load_s ? ctrl_stop_bits : stop2_q;
    par_bit_d = load_s ? parity_bit(pmode_s, data_ext_s, nbits_s) : par_bit_q;
    bit_cnt_d = load_s ? 4'd0 : bit_cnt_q;
    clr_s     = load_s || ctrl_init;
`ifdef UART_TRANSMITTER_EX_BREAK_EN
    brk_hi_d  = brk_hi_q;
`endif
    if (ctrl_init) begin
      state_d   = ST_IDLE;
      txd_d     = 1'b1;
      bit_cnt_d = 4'd0;
`ifdef UART_TRANSMITTER_EX_BREAK_EN
      brk_hi_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (xfer_s) begin
            state_d = ST_START;
            txd_d   = 1'b0;
          end else if (brk_enter_s) begin
`ifdef UART_TRANSMITTER_EX_BREAK_EN
            state_d  = ST_BREAK;
            brk_hi_d = 1'b0;
`endif
            txd_d    = 1'b0;
          end else begin
            txd_d = 1'b1;
          end
        end
        ST_START: begin
          if (tick_s) begin
            state_d = ST_DATA;
            txd_d   = sh_q[0];
          end else state_d = ST_START;
        end
        ST_DATA: begin
          if (tick_s && (bit_cnt_q == (nbits_q - 4'd1))) begin
            bit_cnt_d = 4'd0;
            if (pmode_q != PAR_NONE) begin
              state_d = ST_PARITY;
              txd_d   = par_bit_q;
            end else begin
              state_d = ST_STOP;
              txd_d   = 1'b1;
            end
          end else if (tick_s) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            sh_d      = {1'b0, sh_q[DWIDTH-1:1]};
            txd_d     = sh_q[1];
          end else state_d = ST_DATA;
        end
        ST_PARITY: begin
          if (tick_s) begin
            state_d   = ST_STOP;
            txd_d     = 1'b1;
            bit_cnt_d = 4'd0;
          end else state_d = ST_PARITY;
        end
        ST_STOP: begin
          if (last_stop_s && xfer_s) begin
            state_d = ST_START;
            txd_d   = 1'b0;
          end else if (last_stop_s && brk_enter_s) begin
`ifdef UART_TRANSMITTER_EX_BREAK_EN
            state_d  = ST_BREAK;
            brk_hi_d = 1'b0;
`endif
            txd_d    = 1'b0;
          end else if (last_stop_s) begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
          end else if (tick_s) bit_cnt_d = 4'd1;
          else state_d = ST_STOP;
        end
`ifdef UART_TRANSMITTER_EX_BREAK_EN
        // Hold low for a full frame and until release, then one high stop bit.
        ST_BREAK: begin
          if (brk_hi_q) begin
            txd_d = 1'b1;
            if (tick_s) begin
              state_d  = ST_IDLE;
              brk_hi_d = 1'b0;
            end else state_d = ST_BREAK;
          end else if (brk_done_s && !ctrl_break) begin
            brk_hi_d = 1'b1;
            txd_d    = 1'b1;
            clr_s    = 1'b1;
          end else begin
            txd_d = 1'b0;
            if (tick_s && (bit_cnt_q != fb_s)) bit_cnt_d = bit_cnt_q + 4'd1;
            else bit_cnt_d = bit_cnt_q;
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
          txd_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      txd_q     <= 1'b1;
      bit_cnt_q <= 4'd0;
      sh_q      <= {DWIDTH{1'b0}};
      div_q     <= {BDWIDTH{1'b0}};
      nbits_q   <= 4'(DWIDTH);
      pmode_q   <= PAR_NONE;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      txd_q     <= txd_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      div_q     <= div_d;
      nbits_q   <= nbits_d;
      pmode_q   <= pmode_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
    end
  end

`ifdef UART_TRANSMITTER_EX_BREAK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) brk_hi_q <= 1'b0;
    else brk_hi_q <= brk_hi_d;
  end
`endif

endmodule

// File: tb/tb_uart_transmitter_ex.sv
// Self-checking bench for uart_transmitter_ex: table of frames checked clock-by-clock against a
// scoreboard of expected line levels, plus back-to-back, reset, re-init and break sequences.
module tb_uart_transmitter_ex;

  typedef struct {
    logic [15:0] div;
    logic [3:0]  nb;
    logic [2:0]  pm;
    logic        st;
    logic [8:0]  data;
    int          exp_clks;
    logic        exp_par;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ctrl_init;
  logic [15:0] ctrl_baud_divisor;
  logic [3:0]  ctrl_data_bits;
  logic [2:0]  ctrl_parity_mode;
  logic        ctrl_stop_bits;
  logic        ctrl_break;
  logic [8:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        uart_txd;
  logic        tx_busy;

  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  bit   exp_q[$];
  bit   mon_on   = 1'b0;
  bit   idle_en  = 1'b0;
  vec_t vecs[7];

  uart_transmitter_ex dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .ctrl_init         (ctrl_init),
    .ctrl_baud_divisor (ctrl_baud_divisor),
    .ctrl_data_bits    (ctrl_data_bits),
    .ctrl_parity_mode  (ctrl_parity_mode),
    .ctrl_stop_bits    (ctrl_stop_bits),
    .ctrl_break        (ctrl_break),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .uart_txd          (uart_txd),
    .tx_busy           (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp_v);
    chk_cnt++;
    if (act !== exp_v) $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    else pass_cnt++;
  endtask

  task automatic push_bit(input bit b, input int d);
    for (int k = 0; k < d; k++) exp_q.push_back(b);
  endtask

  // Expected line level for every clock of the frame.
  task automatic push_frame(input vec_t v);
    int d;
    int nb;
    d  = (v.div == 16'd0) ? 1 : int'(v.div);
    nb = ((v.nb < 4'd5) || (v.nb > 4'd9)) ? 9 : int'(v.nb);
    push_bit(1'b0, d);
    for (int i = 0; i < nb; i++) push_bit(v.data[i], d);
    if ((v.pm >= 3'd1) && (v.pm <= 3'd4)) push_bit(v.exp_par, d);
    push_bit(1'b1, d);
    if (v.st) push_bit(1'b1, d);
  endtask

  // Called at negedge+1; returns just after the transfer edge.
  task automatic send(input vec_t v);
    int n;
    ctrl_baud_divisor = v.div;
    ctrl_data_bits    = v.nb;
    ctrl_parity_mode  = v.pm;
    ctrl_stop_bits    = v.st;
    tx_data           = v.data;
    tx_valid          = 1'b1;
    n = 0;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!tx_ready) chk("send_ready_timeout", 0, 1);
    push_frame(v);
    @(posedge clk);
  endtask

  // Counts clocks from the first start-bit clock until tx_ready returns.
  task automatic measure(input string name, input int exp_v, input bit keep);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      if (!keep) tx_valid = 1'b0;
      #1;
      n++;
    end while (!tx_ready && n < 2000);
    chk(name, n, exp_v);
  endtask

  // Scoreboard: compare the line against the expected level each clock.
  always @(negedge clk) begin
    if (mon_on) begin
      if (exp_q.size() > 0) chk("line", int'(uart_txd), int'(exp_q.pop_front()));
      else if (idle_en) chk("idle_line", int'(uart_txd), 1);
    end
  end

  initial begin
    vec_t va;
    vec_t vb;
    int   low;
    int   hi;
    int   exp_low;
    int   exp_hi;
    vecs[0] = '{16'd4, 4'd8, 3'd0, 1'b0, 9'h055, 40, 1'b0};
    vecs[1] = '{16'd3, 4'd7, 3'd2, 1'b1, 9'h003, 33, 1'b1};
    vecs[2] = '{16'd0, 4'd5, 3'd4, 1'b0, 9'h01F, 8,  1'b0};
    vecs[3] = '{16'd2, 4'd9, 3'd1, 1'b0, 9'h1A5, 24, 1'b1};
    vecs[4] = '{16'd1, 4'd6, 3'd3, 1'b1, 9'h1C0, 10, 1'b1};
    vecs[5] = '{16'd5, 4'd3, 3'd6, 1'b0, 9'h0F3, 55, 1'b0};
    vecs[6] = '{16'd2, 4'd8, 3'd2, 1'b0, 9'h0FF, 22, 1'b1};

    reset_n = 1'b0; ctrl_init = 1'b0; ctrl_break = 1'b0; tx_valid = 1'b0;
    ctrl_baud_divisor = 16'd4; ctrl_data_bits = 4'd8; ctrl_parity_mode = 3'd0;
    ctrl_stop_bits = 1'b0; tx_data = 9'h000;
    repeat (3) @(negedge clk);
    chk("reset_txd", int'(uart_txd), 1);
    chk("reset_ready", int'(tx_ready), 1);
    chk("reset_busy", int'(tx_busy), 0);
    reset_n = 1'b1;
    mon_on = 1'b1;
    idle_en = 1'b1;

    for (int i = 0; i < 7; i++) begin
      repeat (3) @(negedge clk);
      #1;
      send(vecs[i]);
      measure($sformatf("frame_clks[%0d]", i), vecs[i].exp_clks, 1'b0);
    end

    // Back-to-back frames with tx_valid held high.
    va = '{16'd2, 4'd9, 3'd3, 1'b0, 9'h1A5, 24, 1'b1};
    vb = '{16'd2, 4'd9, 3'd3, 1'b0, 9'h05A, 24, 1'b1};
    repeat (3) @(negedge clk);
    #1;
    send(va);
    measure("b2b_first", 24, 1'b1);
    send(vb);
    measure("b2b_second", 24, 1'b0);

    // Asynchronous reset in the middle of the data bits.
    va = '{16'd4, 4'd8, 3'd0, 1'b0, 9'h0A5, 40, 1'b0};
    vb = '{16'd3, 4'd8, 3'd1, 1'b0, 9'h03C, 33, 1'b0};
    repeat (3) @(negedge clk);
    #1;
    send(va);
    repeat (12) @(negedge clk);
    #1;
    reset_n = 1'b0;
    tx_valid = 1'b0;
    exp_q.delete();
    #1;
    chk("midreset_txd", int'(uart_txd), 1);
    chk("midreset_ready", int'(tx_ready), 1);
    chk("midreset_busy", int'(tx_busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    send(vb);
    measure("after_reset_clks", 33, 1'b0);

    // Synchronous re-initialisation mid-frame.
    va = '{16'd2, 4'd8, 3'd0, 1'b0, 9'h00F, 20, 1'b0};
    vb = '{16'd1, 4'd5, 3'd2, 1'b1, 9'h015, 9,  1'b0};
    repeat (3) @(negedge clk);
    #1;
    send(va);
    repeat (6) @(negedge clk);
    #1;
    ctrl_init = 1'b1;
    tx_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #1;
    chk("init_busy", int'(tx_busy), 0);
    chk("init_ready", int'(tx_ready), 1);
    ctrl_init = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    send(vb);
    measure("after_init_clks", 9, 1'b0);

    // Break request held for 5 clocks from idle.
`ifdef UART_TRANSMITTER_EX_BREAK_EN
    exp_low = 20;
    exp_hi  = 2;
`else
    exp_low = 0;
    exp_hi  = 0;
`endif
    repeat (3) @(negedge clk);
    #1;
    idle_en = 1'b0;
    ctrl_baud_divisor = 16'd2; ctrl_data_bits = 4'd8; ctrl_parity_mode = 3'd0; ctrl_stop_bits = 1'b0;
    ctrl_break = 1'b1;
    low = 0;
    hi  = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 4) ctrl_break = 1'b0;
      #1;
      if (c == 0 && tx_busy) chk("break_ready_low", int'(tx_ready), 0);
      if (!tx_busy) break;
      if (uart_txd == 1'b0) low++;
      else hi++;
    end
    ctrl_break = 1'b0;
    chk("break_low_clks", low, exp_low);
    chk("break_high_clks", hi, exp_hi);
    chk("break_end_busy", int'(tx_busy), 0);
    chk("break_end_txd", int'(uart_txd), 1);
    idle_en = 1'b1;
    repeat (4) @(negedge clk);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/uart_transmitter_ex.md
UART_TRANSMITTER_EX -- requirements
Module: uart_transmitter_ex

Interface
REQ-001 Parameter BDWIDTH, default 16: baud divisor width.
REQ-002 Parameter DWIDTH, default 9: maximum data bits per frame; legal range 5..9.
REQ-003 Port reset_n  input  1  asynchronous active-low reset.
REQ-004 Port clk  input  1  single clock; all logic rising-edge.
REQ-005 Port ctrl_init  input  1  synchronous re-initialisation, same effect as reset.
REQ-006 Port ctrl_baud_divisor  input  BDWIDTH  clocks per bit; 0 treated as 1.
REQ-007 Port ctrl_data_bits  input  4  data bits per frame, 5..DWIDTH; out-of-range values clamp to DWIDTH.
REQ-008 Port ctrl_parity_mode  input  3  0 none, 1 even, 2 odd, 3 mark (1), 4 space (0); 5..7 treated as none.
REQ-009 Port ctrl_stop_bits  input  1  0 one stop bit, 1 two stop bits.
REQ-010 Port ctrl_break  input  1  level request to hold the line low (break).
REQ-011 Port tx_data / tx_valid / tx_ready  input DWIDTH / input 1 / output 1  streaming input; LSB sent first; bits above ctrl_data_bits ignored.
REQ-012 Port uart_txd  output  1  serial line, idle high.
REQ-013 Port tx_busy  output  1  high while a frame or break is on the line.

Function
REQ-014 FSM states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-015 Transfer occurs on tx_valid & tx_ready; all ctrl_* values except ctrl_init and ctrl_break are latched at transfer and held for the frame.
REQ-016 Bit timer counts 0..divisor-1; each bit lasts exactly the latched divisor in clocks.
REQ-017 uart_txd is registered; the start bit (0) appears the cycle after transfer.
REQ-018 Sequence: START, then DATA (ctrl_data_bits, LSB first), then PARITY (only if mode is 1..4), then STOP (1 or 2 bits, high).
REQ-019 Even parity = XOR of the sent data bits; odd parity = its inverse.
REQ-020 tx_ready is high in IDLE, and also in the last clock of the last stop bit, so back-to-back frames have zero idle gap.
REQ-021 tx_valid low at frame end causes a return to IDLE with uart_txd high.
REQ-022 ctrl_break sampled in IDLE, or at frame end with no transfer, enters BREAK: uart_txd=0, tx_ready=0, tx_busy=1.
REQ-023 BREAK exits on ctrl_break low after at least one full frame time (start + data + parity + stop bits of the current ctrl_* settings), then one stop bit high, then IDLE.
REQ-024 ctrl_break asserted mid-frame does not disturb the current frame.
REQ-025 tx_busy = state != IDLE.

Reset
REQ-026 reset_n low, or ctrl_init high, forces: state IDLE, uart_txd=1, tx_ready=1, tx_busy=0, counters 0.
REQ-027 Reset or ctrl_init mid-frame aborts the frame; the line goes high the next cycle and no partial-frame recovery is performed.

Configuration
REQ-028 Macro UART_TRANSMITTER_EX_BREAK_EN defined: BREAK state and ctrl_break function as specified.
REQ-029 Macro undefined: ctrl_break port remains but is ignored, BREAK state is absent, and no break logic is synthesised.

Structure
REQ-030 Package uart_pkg holds the parity-mode enum, the FSM state enum, and the constants DATA_BITS_MIN=5 and DATA_BITS_MAX=9.
REQ-031 Sub-module uart_baud_tick (BDWIDTH) provides the bit-period tick with clear-on-start; the FSM, shifter and parity logic stay in the top module.

Verification
REQ-032 Divisor 4, 8 data bits, no parity, 1 stop, tx_data 0x55 -> line 0,1,0,1,0,1,0,1,0,1, each bit 4 clk; tx_ready returns on clock 40.
REQ-033 Divisor 3, 7 data bits, odd parity, 2 stop, data 0x03 -> parity bit 1, frame of 11 bits = 33 clk.
REQ-034 Divisor 2, 9 data bits, mark parity, two frames with tx_valid held high -> second start bit immediately follows the stop bit, with no idle gap.
REQ-035 Divisor 0 treated as 1; 5 data bits, space parity, data 0x1F -> 8 bits of 1 clk each, parity bit 0.
REQ-036 With UART_TRANSMITTER_EX_BREAK_EN, ctrl_break held for 5 clk, divisor 2, 8N1 -> line low for 20 clk, high for 2 clk, then IDLE; without the macro the line stays high.
REQ-037 reset_n pulsed low during DATA -> uart_txd=1, tx_ready=1 and tx_busy=0 immediately; next frame transmits correctly.
